// File: rtl/bsg_trace_replay_pkg.sv
// Shared definitions for the multi-channel FSB trace replay engine:
// instruction opcodes and replay FSM states.
package bsg_trace_replay_pkg;

    localparam int bsg_trace_op_width_gp = 4;

    typedef enum logic [bsg_trace_op_width_gp-1:0] {
        e_trace_nop   = 4'd0,
        e_trace_send  = 4'd1,
        e_trace_recv  = 4'd2,
        e_trace_done  = 4'd3,
        e_trace_wait  = 4'd4,
        e_trace_chsel = 4'd5
    } bsg_trace_op_e;

    typedef enum logic [1:0] {
        eRUN  = 2'd0,
        eWAIT = 2'd1,
        eDONE = 2'd2
    } bsg_trace_state_e;

endpackage

// File: rtl/bsg_trace_wait_counter.sv
// Loadable down-counter timing WAIT instructions; last_o flags the final
// cycle of a wait so the replay FSM can advance without a bubble.
module bsg_trace_wait_counter #(
    parameter int width_p = 16
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               load_i,
    input  logic [width_p-1:0] load_val_i,
    input  logic               dec_i,
    output logic               zero_o,
    output logic               last_o
);

    logic [width_p-1:0] count_r;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)               count_r <= '0;
        else if (load_i)           count_r <= load_val_i;
        else if (dec_i && !zero_o) count_r <= count_r - width_p'(1);
    end

    assign zero_o = (count_r == '0);
    assign last_o = (count_r == width_p'(1));

endmodule

// File: rtl/bsg_fsb_trace_replay_mc.sv
// Multi-channel FSB trace replay: steps through a combinational ROM of
// {opcode, payload} words, sending, checking and pacing traffic per channel.
module bsg_fsb_trace_replay_mc
    import bsg_trace_replay_pkg::*;
#(
    parameter int channels_p       = 2,
    parameter int ring_width_p     = 80,
    parameter int rom_addr_width_p = 10,
    parameter int wait_width_p     = 16,
    localparam int sel_width_lp    = (channels_p > 1) ? $clog2(channels_p) : 1,
    localparam int rom_width_lp    = bsg_trace_op_width_gp + ring_width_p
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             en_i,

    input  logic [channels_p-1:0]            v_i,
    input  logic [channels_p*ring_width_p-1:0] data_i,
    output logic [channels_p-1:0]            ready_o,

    output logic [channels_p-1:0]            v_o,
    output logic [ring_width_p-1:0]          data_o,
    input  logic [channels_p-1:0]            yumi_i,

    output logic [rom_addr_width_p-1:0]      rom_addr_o,
    input  logic [rom_width_lp-1:0]          rom_data_i,

    output logic                             done_o,
    output logic                             error_o,
    output logic [sel_width_lp-1:0]          sel_o
);

    bsg_trace_state_e              state_r, state_n;
    logic [rom_addr_width_p-1:0]   addr_r, addr_n;
    logic [sel_width_lp-1:0]       sel_r, sel_n;
    logic                          error_r, error_n;

    bsg_trace_op_e                 op;
    logic [ring_width_p-1:0]       payload;
    logic [ring_width_p-1:0]       recv_data;
    logic [wait_width_p-1:0]       wait_val;
    logic                          chsel_ok;
    logic                          active;
    logic                          advance;
    logic                          wait_load, wait_dec, wait_zero, wait_last;

    assign op        = bsg_trace_op_e'(rom_data_i[ring_width_p +: bsg_trace_op_width_gp]);
    assign payload   = rom_data_i[ring_width_p-1:0];
    assign recv_data = data_i[int'(sel_r) * ring_width_p +: ring_width_p];
    assign wait_val  = payload[wait_width_p-1:0];
    assign chsel_ok  = (payload < ring_width_p'(channels_p));

    // Reset also gates the handshake outputs since the ROM word at address 0 is live during reset.
    assign active = en_i & ~reset_i;

    bsg_trace_wait_counter #(
        .width_p (wait_width_p)
    ) wait_counter (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .load_i     (wait_load),
        .load_val_i (wait_val),
        .dec_i      (wait_dec),
        .zero_o     (wait_zero),
        .last_o     (wait_last)
    );

    always_comb begin
        // NOTE: every signal driven here gets a default first so no latches are inferred.
        state_n   = state_r;
        addr_n    = addr_r;
        sel_n     = sel_r;
        error_n   = error_r;
        advance   = 1'b0;
        wait_load = 1'b0;
        wait_dec  = 1'b0;
        v_o       = '0;
        ready_o   = '0;
        data_o    = '0;

        if (active) begin
            unique case (state_r)
                eRUN: begin
                    case (op)
                        e_trace_nop: advance = 1'b1;
                        e_trace_send: begin
                            v_o[sel_r] = 1'b1;
                            data_o     = payload;
                            advance    = yumi_i[sel_r];
                        end
                        e_trace_recv: begin
                            ready_o[sel_r] = 1'b1;
                            if (v_i[sel_r]) begin
                                advance = 1'b1;
                                if (recv_data != payload) error_n = 1'b1;
                            end
                        end
                        e_trace_done: state_n = eDONE;
                        e_trace_wait: begin
                            // The decode cycle is the first of the n+1 wait cycles.
                            wait_load = 1'b1;
                            if (wait_val == '0) advance = 1'b1;
                            else                state_n = eWAIT;
                        end
                        e_trace_chsel: begin
                            advance = 1'b1;
                            if (chsel_ok) sel_n   = payload[sel_width_lp-1:0];
                            else          error_n = 1'b1;
                        end
                        default: begin
                            advance = 1'b1;
                            error_n = 1'b1;
                        end
                    endcase
                end
                eWAIT: begin
                    wait_dec = 1'b1;
                    if (wait_last || wait_zero) begin
                        advance = 1'b1;
                        state_n = eRUN;
                    end
                end
                default: ;
            endcase
        end

        if (advance) addr_n = addr_r + rom_addr_width_p'(1);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= eRUN;
            addr_r  <= '0;
            sel_r   <= '0;
            error_r <= 1'b0;
        end else begin
            state_r <= state_n;
            addr_r  <= addr_n;
            sel_r   <= sel_n;
            error_r <= error_n;
        end
    end

    assign rom_addr_o = en_i ? addr_r : '0;
    assign done_o     = (state_r == eDONE);
    assign error_o    = error_r;
    assign sel_o      = sel_r;

endmodule

// File: tb/tb_bsg_fsb_trace_replay_mc.sv
// Self-checking bench for bsg_fsb_trace_replay_mc: directed scenarios plus
// randomized programs compared against an instruction-level replay model.
module tb_bsg_fsb_trace_replay_mc;

    localparam int CH    = 2;
    localparam int RW    = 80;
    localparam int AW    = 4;
    localparam int WW    = 16;
    localparam int ROMW  = RW + 4;
    localparam int DEPTH = 1 << AW;

    logic             clk = 1'b0;
    logic             reset_i, en_i;
    logic [CH-1:0]    v_i, ready_o, v_o, yumi_i;
    logic [CH*RW-1:0] data_i;
    logic [RW-1:0]    data_o;
    logic [AW-1:0]    rom_addr_o;
    logic [ROMW-1:0]  rom_data_i;
    logic             done_o, error_o;
    logic [0:0]       sel_o;

    logic [ROMW-1:0]  rom [DEPTH];

    int errors = 0;
    int checks = 0;

    // Instruction-level model state
    logic [AW-1:0] m_pc;
    int            m_sel;
    bit            m_err, m_done, m_in_wait;
    int            m_wait_left;

    logic [CH-1:0] exp_v, exp_ready;
    logic [RW-1:0] exp_data;
    logic [AW-1:0] exp_addr;

    always #5 clk = ~clk;

    assign rom_data_i = rom[rom_addr_o];

    bsg_fsb_trace_replay_mc #(
        .channels_p       (CH),
        .ring_width_p     (RW),
        .rom_addr_width_p (AW),
        .wait_width_p     (WW)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .en_i       (en_i),
        .v_i        (v_i),
        .data_i     (data_i),
        .ready_o    (ready_o),
        .v_o        (v_o),
        .data_o     (data_o),
        .yumi_i     (yumi_i),
        .rom_addr_o (rom_addr_o),
        .rom_data_i (rom_data_i),
        .done_o     (done_o),
        .error_o    (error_o),
        .sel_o      (sel_o)
    );

    function automatic logic [ROMW-1:0] ins(input logic [3:0] op, input logic [RW-1:0] pl);
        return {op, pl};
    endfunction

    task automatic fill_rom(input logic [ROMW-1:0] w);
        for (int i = 0; i < DEPTH; i++) rom[i] = w;
    endtask

    task automatic model_reset();
        m_pc = '0; m_sel = 0; m_err = 0; m_done = 0; m_in_wait = 0; m_wait_left = 0;
    endtask

    // Expected outputs for the current cycle, given model state and current inputs.
    task automatic model_eval();
        logic [3:0]    op;
        logic [RW-1:0] pl;
        exp_v     = '0;
        exp_ready = '0;
        exp_data  = '0;
        exp_addr  = en_i ? m_pc : '0;
        if (en_i && !reset_i && !m_done && !m_in_wait) begin
            op = rom[m_pc][ROMW-1 -: 4];
            pl = rom[m_pc][RW-1:0];
            if (op == 4'd1) begin
                exp_v[m_sel] = 1'b1;
                exp_data     = pl;
            end else if (op == 4'd2) begin
                exp_ready[m_sel] = 1'b1;
            end
        end
    endtask

    // Retire one clock of the trace: each instruction occupies a number of
    // enabled cycles set by its handshake or wait count.
    task automatic model_step();
        logic [3:0]    op;
        logic [RW-1:0] pl;
        if (!en_i || reset_i || m_done) return;
        if (m_in_wait) begin
            m_wait_left--;
            if (m_wait_left == 0) begin
                m_in_wait = 0;
                m_pc      = m_pc + 1'b1;
            end
            return;
        end
        op = rom[m_pc][ROMW-1 -: 4];
        pl = rom[m_pc][RW-1:0];
        case (op)
            4'd0: m_pc = m_pc + 1'b1;
            4'd1: if (yumi_i[m_sel]) m_pc = m_pc + 1'b1;
            4'd2: if (v_i[m_sel]) begin
                if (data_i[m_sel*RW +: RW] != pl) m_err = 1;
                m_pc = m_pc + 1'b1;
            end
            4'd3: m_done = 1;
            4'd4: if (pl[WW-1:0] == '0) m_pc = m_pc + 1'b1;
                  else begin
                      m_in_wait   = 1;
                      m_wait_left = int'(pl[WW-1:0]);
                  end
            4'd5: begin
                if (pl < RW'(CH)) m_sel = int'(pl[0]);
                else              m_err = 1;
                m_pc = m_pc + 1'b1;
            end
            default: begin
                m_err = 1;
                m_pc  = m_pc + 1'b1;
            end
        endcase
    endtask

    task automatic sample();
        @(negedge clk);
        model_eval();
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        en_i    = 1'b1;
        v_i     = '0;
        yumi_i  = '0;
        data_i  = '0;
        model_reset();
        @(posedge clk);
        #1;
        reset_i = 1'b0;
    endtask

    task automatic test_reset();
        fill_rom(ins(4'd0, '0));
        rom[0]  = ins(4'd1, RW'(80'h77));
        reset_i = 1'b1;
        en_i    = 1'b1;
        yumi_i  = '0;
        v_i     = '0;
        data_i  = '0;
        #2;
        checks++; if (v_o !== 2'b00)     begin errors++; $display("FAIL reset_v_o got=%b exp=00", v_o); end
        checks++; if (ready_o !== 2'b00) begin errors++; $display("FAIL reset_ready_o got=%b exp=00", ready_o); end
        checks++; if (rom_addr_o !== '0) begin errors++; $display("FAIL reset_addr got=%0d exp=0", rom_addr_o); end
        checks++; if (done_o !== 1'b0)   begin errors++; $display("FAIL reset_done got=%b exp=0", done_o); end
        checks++; if (error_o !== 1'b0)  begin errors++; $display("FAIL reset_error got=%b exp=0", error_o); end
        checks++; if (sel_o !== 1'b0)    begin errors++; $display("FAIL reset_sel got=%b exp=0", sel_o); end
        @(posedge clk); #1;
        reset_i = 1'b0;
        model_reset();
        sample();
        checks++; if (v_o !== 2'b01) begin errors++; $display("FAIL post_reset_send got=%b exp=01", v_o); end
        tick();
    endtask

    task automatic test_send();
        fill_rom(ins(4'd0, '0));
        rom[0] = ins(4'd1, RW'(80'h5));
        rom[1] = ins(4'd3, '0);
        do_reset();
        for (int c = 0; c < 4; c++) begin
            yumi_i = (c == 3) ? 2'b01 : 2'b00;
            sample();
            checks++; if (v_o !== 2'b01)      begin errors++; $display("FAIL send_v_o c=%0d got=%b exp=01", c, v_o); end
            checks++; if (data_o !== RW'(5))  begin errors++; $display("FAIL send_data c=%0d got=%h exp=5", c, data_o); end
            tick();
        end
        yumi_i = '0;
        sample();
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL send_done_early got=%b exp=0", done_o); end
        checks++; if (v_o !== 2'b00)   begin errors++; $display("FAIL send_v_o_after got=%b exp=00", v_o); end
        tick();
        sample();
        checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL send_done got=%b exp=1", done_o); end
        tick();
        sample();
        checks++; if (rom_addr_o !== AW'(1)) begin errors++; $display("FAIL done_addr_hold got=%0d exp=1", rom_addr_o); end
        tick();
    endtask

    task automatic test_recv();
        fill_rom(ins(4'd0, '0));
        rom[0] = ins(4'd5, RW'(1));
        rom[1] = ins(4'd2, RW'(80'hA));
        rom[2] = ins(4'd3, '0);
        do_reset();
        v_i    = 2'b10;
        data_i = {RW'(80'hB), RW'(0)};
        sample();
        checks++; if (ready_o !== 2'b00) begin errors++; $display("FAIL recv_ready_chsel got=%b exp=00", ready_o); end
        tick();
        sample();
        checks++; if (ready_o !== 2'b10) begin errors++; $display("FAIL recv_ready got=%b exp=10", ready_o); end
        checks++; if (sel_o !== 1'b1)    begin errors++; $display("FAIL recv_sel got=%b exp=1", sel_o); end
        checks++; if (error_o !== 1'b0)  begin errors++; $display("FAIL recv_error_early got=%b exp=0", error_o); end
        tick();
        sample();
        checks++; if (error_o !== 1'b1)  begin errors++; $display("FAIL recv_error got=%b exp=1", error_o); end
        tick();
        sample();
        checks++; if (done_o !== 1'b1)   begin errors++; $display("FAIL recv_done got=%b exp=1", done_o); end
        checks++; if (error_o !== 1'b1)  begin errors++; $display("FAIL recv_error_sticky got=%b exp=1", error_o); end
        tick();
    endtask

    task automatic test_wait();
        int first;
        fill_rom(ins(4'd0, '0));
        rom[0] = ins(4'd4, RW'(3));
        rom[1] = ins(4'd1, RW'(1));
        rom[2] = ins(4'd3, '0);
        do_reset();
        yumi_i = 2'b11;
        first  = -1;
        for (int c = 0; c < 10 && first < 0; c++) begin
            sample();
            if (v_o[0] === 1'b1) begin
                first = c;
                checks++; if (data_o !== RW'(1)) begin errors++; $display("FAIL wait_send_data got=%h exp=1", data_o); end
            end
            tick();
        end
        checks++; if (first != 4) begin errors++; $display("FAIL wait_latency got=%0d exp=4", first); end
    endtask

    task automatic test_chsel_illegal();
        fill_rom(ins(4'd0, '0));
        rom[0] = ins(4'd5, RW'(7));
        do_reset();
        sample();
        checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL chsel_err_early got=%b exp=0", error_o); end
        tick();
        sample();
        checks++; if (error_o !== 1'b1)       begin errors++; $display("FAIL chsel_err got=%b exp=1", error_o); end
        checks++; if (sel_o !== 1'b0)         begin errors++; $display("FAIL chsel_sel got=%b exp=0", sel_o); end
        checks++; if (rom_addr_o !== AW'(1))  begin errors++; $display("FAIL chsel_addr got=%0d exp=1", rom_addr_o); end
        tick();

        fill_rom(ins(4'd0, '0));
        rom[0] = ins(4'hF, '0);
        do_reset();
        sample();
        checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL illegal_err_early got=%b exp=0", error_o); end
        tick();
        sample();
        checks++; if (error_o !== 1'b1)      begin errors++; $display("FAIL illegal_err got=%b exp=1", error_o); end
        checks++; if (rom_addr_o !== AW'(1)) begin errors++; $display("FAIL illegal_addr got=%0d exp=1", rom_addr_o); end
        tick();
    endtask

    task automatic test_en_freeze();
        int enabled_before;
        int bad_frozen;
        bit risen;
        fill_rom(ins(4'd0, '0));
        rom[0] = ins(4'd4, RW'(5));
        rom[1] = ins(4'd1, RW'(2));
        rom[2] = ins(4'd3, '0);
        do_reset();
        enabled_before = 0;
        bad_frozen     = 0;
        risen          = 0;
        for (int c = 0; c < 40 && !risen; c++) begin
            en_i = !(c >= 2 && c < 12);
            sample();
            if (!en_i) begin
                if (v_o !== 2'b00 || ready_o !== 2'b00 || rom_addr_o !== '0 || data_o !== '0) bad_frozen++;
            end else if (v_o[0] === 1'b1) begin
                risen = 1;
            end else begin
                enabled_before++;
            end
            if (!risen) tick();
        end
        checks++; if (bad_frozen != 0)     begin errors++; $display("FAIL freeze_outputs bad_cycles=%0d exp=0", bad_frozen); end
        checks++; if (enabled_before != 6) begin errors++; $display("FAIL freeze_wait_span got=%0d exp=6", enabled_before); end
        @(posedge clk); #1;
        reset_i = 1'b1;
        model_reset();
        #1;
        checks++; if (v_o !== 2'b00)     begin errors++; $display("FAIL midsend_reset_v_o got=%b exp=00", v_o); end
        checks++; if (rom_addr_o !== '0) begin errors++; $display("FAIL midsend_reset_addr got=%0d exp=0", rom_addr_o); end
        @(posedge clk); #1;
        reset_i = 1'b0;
        sample();
        checks++; if (v_o !== 2'b00) begin errors++; $display("FAIL post_abort_v_o got=%b exp=00", v_o); end
        tick();
    endtask

    task automatic test_wrap();
        int bad;
        fill_rom(ins(4'd0, '0));
        do_reset();
        bad = 0;
        for (int c = 0; c < DEPTH + 2; c++) begin
            sample();
            if (rom_addr_o !== AW'(c % DEPTH)) bad++;
            if (c == DEPTH) begin
                checks++; if (rom_addr_o !== '0) begin errors++; $display("FAIL wrap_addr got=%0d exp=0", rom_addr_o); end
            end
            tick();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL wrap_sequence bad_cycles=%0d exp=0", bad); end
    endtask

    task automatic test_random();
        int r;
        for (int round = 0; round < 5; round++) begin
            for (int i = 0; i < DEPTH; i++) begin
                r = $urandom_range(0, 19);
                if (r < 4)       rom[i] = ins(4'd0, RW'($urandom));
                else if (r < 9)  rom[i] = ins(4'd1, RW'({$urandom, $urandom, $urandom}));
                else if (r < 13) rom[i] = ins(4'd2, RW'($urandom_range(0, 3)));
                else if (r < 16) rom[i] = ins(4'd4, RW'($urandom_range(0, 4)));
                else if (r < 18) rom[i] = ins(4'd5, RW'($urandom_range(0, 2)));
                else if (r < 19) rom[i] = ins(4'($urandom_range(6, 15)), '0);
                else             rom[i] = ins(4'd3, '0);
            end
            do_reset();
            for (int c = 0; c < 150; c++) begin
                en_i   = ($urandom_range(0, 9) != 0);
                yumi_i = CH'($urandom);
                v_i    = CH'($urandom);
                data_i = {RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3))};
                sample();
                checks++; if (v_o !== exp_v)          begin errors++; $display("FAIL rand_v_o r=%0d c=%0d got=%b exp=%b", round, c, v_o, exp_v); end
                checks++; if (ready_o !== exp_ready)  begin errors++; $display("FAIL rand_ready r=%0d c=%0d got=%b exp=%b", round, c, ready_o, exp_ready); end
                checks++; if (rom_addr_o !== exp_addr) begin errors++; $display("FAIL rand_addr r=%0d c=%0d got=%0d exp=%0d", round, c, rom_addr_o, exp_addr); end
                checks++; if (done_o !== m_done)      begin errors++; $display("FAIL rand_done r=%0d c=%0d got=%b exp=%b", round, c, done_o, m_done); end
                checks++; if (error_o !== m_err)      begin errors++; $display("FAIL rand_error r=%0d c=%0d got=%b exp=%b", round, c, error_o, m_err); end
                checks++; if (sel_o !== 1'(m_sel))    begin errors++; $display("FAIL rand_sel r=%0d c=%0d got=%b exp=%0d", round, c, sel_o, m_sel); end
                if (exp_v != '0 || !en_i) begin
                    checks++; if (data_o !== exp_data) begin errors++; $display("FAIL rand_data r=%0d c=%0d got=%h exp=%h", round, c, data_o, exp_data); end
                end
                tick();
            end
        end
    endtask

    initial begin
        reset_i = 1'b1;
        en_i    = 1'b0;
        v_i     = '0;
        yumi_i  = '0;
        data_i  = '0;
        fill_rom(ins(4'd0, '0));
        model_reset();
        @(posedge clk); #1;
        test_reset();
        test_send();
        test_recv();
        test_wait();
        test_chsel_illegal();
        test_en_freeze();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
